mont_redc256: RTL

Sequential Montgomery reduction for the SM2 datapath: takes a 512-bit product T (as delivered by the 256-bit multiplier's `c` output) and returns r = T·2^-256 mod p. It is the reduction half of the SOS flow. It iterates a single combinational 64×64 multiplier over four 64-bit words, then performs one final conditional subtraction. It sits between the 256-bit multiplier and the point-arithmetic controller.

---
 rtl/sm2_pkg.sv | 19 +
 rtl/mul64.sv | 10 +
 rtl/mont_redc256.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sm2_pkg.sv
// Shared SM2 datapath constants and the Montgomery reducer state encoding.
package sm2_pkg;

  localparam int W  = 64;
  localparam int NW = 4;

  typedef enum logic [2:0] {
    IDLE,
    CALC_M,
    MAC,
    PROP,
    FINAL
  } state_t;

  localparam logic [NW*W-1:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [W-1:0] SM2_N0INV = 64'h1;

endpackage

// File: rtl/mul64.sv
// Combinational 64x64 -> 128 unsigned multiplier shared by the reduction datapath.
module mul64 (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] c
);

  assign c = {64'd0, a} * {64'd0, b};

endmodule

// File: rtl/mont_redc256.sv
// Word-serial Montgomery reduction r = T * 2^-256 mod p using one shared 64x64 multiplier.
//
// state  | meaning
// IDLE   | waiting for a start rising edge; r holds the last result
// CALC_M | m = t_w[i] * n0inv mod 2^64
// MAC    | accumulate m * p[j] into t_w[i+j] with carry, j = 0..3
// PROP   | ripple the MAC carry into t_w[8:i+4], advance i
// FINAL  | conditional subtract of p from t_w[8:4], raise done
module mont_redc256
  import sm2_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [2*NW*W-1:0] t,
  input  logic [NW*W-1:0]   p,
  input  logic [W-1:0]      n0inv,
  output logic [NW*W-1:0]   r,
  output logic              done
);

  state_t                  state;
  logic [2*NW:0][W-1:0]    t_w;
  logic [NW*W-1:0]         p_q;
  logic [W-1:0]            n0inv_q;
  logic [W-1:0]            m;
  logic [W-1:0]            carry;
  logic [1:0]              i;
  logic [1:0]              j;
  logic                    start_q;

  logic [W-1:0]            mul_a;
  logic [W-1:0]            mul_b;
  logic [2*W-1:0]          mul_c;
  logic [2:0]              mac_idx;
  logic [2*W-1:0]          mac_sum;
  logic [2:0]              hi_word;
  logic [9:0]              prop_shamt;
  logic [(2*NW+1)*W-1:0]   prop_sum;
  logic [NW*W:0]           u;
  logic [NW*W:0]           u_minus_p;

  always_comb begin
    mul_a = t_w[{2'b00, i}];
    mul_b = n0inv_q;
    if (state == MAC) begin
      mul_a = m;
      mul_b = p_q[{j, 6'd0} +: W];
    end
  end

  mul64 u_mul (
    .a(mul_a),
    .b(mul_b),
    .c(mul_c)
  );

  assign mac_idx    = {1'b0, i} + {1'b0, j};
  assign mac_sum    = mul_c + {{W{1'b0}}, t_w[{1'b0, mac_idx}]} + {{W{1'b0}}, carry};
  assign hi_word    = {1'b0, i} + 3'd4;
  assign prop_shamt = {1'b0, hi_word, 6'd0};
  assign prop_sum   = t_w + ({{(2*NW*W){1'b0}}, carry} << prop_shamt);

  // u < 2p, so the borrow out of u - p is set exactly when u < p
  assign u         = {t_w[8][0], t_w[7], t_w[6], t_w[5], t_w[4]};
  assign u_minus_p = u - {1'b0, p_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      t_w     <= '0;
      p_q     <= '0;
      n0inv_q <= '0;
      m       <= '0;
      carry   <= '0;
      i       <= '0;
      j       <= '0;
      start_q <= 1'b0;
      r       <= '0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            t_w     <= {{W{1'b0}}, t};
            p_q     <= p;
            n0inv_q <= n0inv;
            carry   <= '0;
            i       <= '0;
            j       <= '0;
            state   <= CALC_M;
          end
        end
        CALC_M: begin
          m     <= mul_c[W-1:0];
          j     <= '0;
          state <= MAC;
        end
        MAC: begin
          {carry, t_w[{1'b0, mac_idx}]} <= mac_sum;
          j <= j + 2'd1;
          if (j == 2'(NW-1)) state <= PROP;
        end
        PROP: begin
          t_w   <= prop_sum;
          carry <= '0;
          if (i == 2'(NW-1)) begin
            state <= FINAL;
          end else begin
            i     <= i + 2'd1;
            state <= CALC_M;
          end
        end
        FINAL: begin
          r     <= u_minus_p[NW*W] ? u[NW*W-1:0] : u_minus_p[NW*W-1:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
